// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FIFO: control-state encodings and depth helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fifo_pkg;

  // Control state, one per sampled request combination. The encodings are
  // fixed because other blocks decode them directly.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,  // no request
    ST_WRITE    = 3'b001,  // write accepted (also used for write+read while empty)
    ST_READ     = 3'b010,  // read accepted
    ST_WR_ERROR = 3'b011,  // write rejected, FIFO full
    ST_RD_ERROR = 3'b100,  // read rejected, FIFO empty
    ST_WR_RD    = 3'b101   // write and read both accepted
  } fifo_state_e;

  // Number of entries addressed by an ADDR_WIDTH-bit pointer.
  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/fifo_param_if.sv
// Request/status bundle between a FIFO user (master) and the FIFO (slave).
// Latency: n/a (wiring only); all slave outputs are driven from registers.
// Backpressure: none; overflow/underflow is reported via wr_err/rd_err pulses.
//
// Signals:
//   wr_en, rd_en, din          master -> slave request and write data
//   dout                       registered read data
//   full, empty                registered status flags
//   almost_full, almost_empty  registered threshold flags
//   data_count                 registered occupancy, 0..DEPTH
//   wr_ack, rd_ack             one-cycle pulse: previous-cycle request accepted
//   wr_err, rd_err             one-cycle pulse: previous-cycle request rejected
interface fifo_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
);

  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   data_count;
  logic                  wr_ack;
  logic                  rd_ack;
  logic                  wr_err;
  logic                  rd_err;

  modport master (
    output wr_en, rd_en, din,
    input  dout, full, empty, almost_full, almost_empty, data_count,
    input  wr_ack, rd_ack, wr_err, rd_err
  );

  modport slave (
    input  wr_en, rd_en, din,
    output dout, full, empty, almost_full, almost_empty, data_count,
    output wr_ack, rd_ack, wr_err, rd_err
  );

endinterface

// File: rtl/fifo_p_cal_addr.sv
// Pointer/count calculator: turns the chosen control state into memory strobes and next pointers.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the state already encodes whether a request was accepted.
//
// Ports:
//   state_i                    control state chosen for this edge
//   head_i, tail_i, count_i    current read pointer, write pointer, occupancy
//   we_o, re_o                 memory write / read strobes
//   next_head_o, next_tail_o   pointers after this edge (wrap modulo DEPTH)
//   next_count_o               occupancy after this edge
module fifo_p_cal_addr
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 3
) (
  input  fifo_state_e           state_i,
  input  logic [ADDR_WIDTH-1:0] head_i,
  input  logic [ADDR_WIDTH-1:0] tail_i,
  input  logic [ADDR_WIDTH:0]   count_i,
  output logic                  we_o,
  output logic                  re_o,
  output logic [ADDR_WIDTH-1:0] next_head_o,
  output logic [ADDR_WIDTH-1:0] next_tail_o,
  output logic [ADDR_WIDTH:0]   next_count_o
);

  localparam int CW = ADDR_WIDTH + 1;

  always_comb begin
    we_o         = 1'b0;
    re_o         = 1'b0;
    next_head_o  = head_i;
    next_tail_o  = tail_i;
    next_count_o = count_i;

    unique case (state_i)
      ST_WRITE: begin
        we_o         = 1'b1;
        next_tail_o  = tail_i + ADDR_WIDTH'(1);
        next_count_o = count_i + CW'(1);
      end
      ST_READ: begin
        re_o         = 1'b1;
        next_head_o  = head_i + ADDR_WIDTH'(1);
        next_count_o = count_i - CW'(1);
      end
      ST_WR_RD: begin
        // One in, one out: occupancy is unchanged, both pointers advance.
        we_o        = 1'b1;
        re_o        = 1'b1;
        next_head_o = head_i + ADDR_WIDTH'(1);
        next_tail_o = tail_i + ADDR_WIDTH'(1);
      end
      default: begin
        // IDLE and both error states leave pointers and count alone.
      end
    endcase
  end

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with registered control FSM, flags and ack/err pulses.
// Latency: write at edge N readable by a read sampled at edge N+1; read data valid after the accepting edge.
// Backpressure: none; writes when full / reads when empty are dropped and flagged with wr_err / rd_err.
//
// Ports:
//   clk    single clock, all state on the rising edge
//   reset  asynchronous active-high reset; discards all entries
//   bus    fifo_param_if slave modport (requests, data, flags, pulses)
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int AFULL_TH   = fifo_depth(ADDR_WIDTH) - 1,
  parameter int AEMPTY_TH  = 1
) (
  input  logic         clk,
  input  logic         reset,
  fifo_param_if.slave  bus
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int CW    = ADDR_WIDTH + 1;

  // Thresholds sized to the count register so compares stay width-matched.
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  fifo_state_e           state_q, state_d;
  logic                  rd_rej_q, rd_rej_d;
  logic [ADDR_WIDTH-1:0] head_q, tail_q;
  logic [CW-1:0]         count_q;
  logic                  full_q, empty_q, afull_q, aempty_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  we, re;
  logic [ADDR_WIDTH-1:0] head_d, tail_d;
  logic [CW-1:0]         count_d;

  // ---------------------------------------------------------------------------
  // Control FSM: next state from the sampled requests and the registered flags.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = ST_IDLE;
    rd_rej_d = 1'b0;

    unique case ({bus.wr_en, bus.rd_en})
      2'b10: state_d = full_q  ? ST_WR_ERROR : ST_WRITE;
      2'b01: state_d = empty_q ? ST_RD_ERROR : ST_READ;
      2'b11: begin
        if (empty_q) begin
          // Nothing to read yet: take the write, refuse the read. The refusal
          // is remembered separately because the state itself says WRITE.
          state_d  = ST_WRITE;
          rd_rej_d = 1'b1;
        end else begin
          // Covers the full case too: the read frees the slot the write fills.
          state_d = ST_WR_RD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rd_rej_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_rej_q <= rd_rej_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointer / count arithmetic for the state being entered at this edge.
  // ---------------------------------------------------------------------------
  fifo_p_cal_addr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_cal_addr (
    .state_i      (state_d),
    .head_i       (head_q),
    .tail_i       (tail_q),
    .count_i      (count_q),
    .we_o         (we),
    .re_o         (re),
    .next_head_o  (head_d),
    .next_tail_o  (tail_d),
    .next_count_o (count_d)
  );

  // Pointers, count, flags and read data. Flags come from the next count so
  // they change on the same edge as the operation that moves the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      dout_q   <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
      afull_q  <= (count_d >= AFULL_C);
      aempty_q <= (count_d <= AEMPTY_C);
      // Reads the pre-edge array, so a simultaneous write to the same slot
      // (full FIFO, WR_RD) still returns the old head entry.
      if (re) begin
        dout_q <= mem_q[head_q];
      end
    end
  end

  // Storage array; contents are don't-care after reset so it carries none.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[tail_q] <= bus.din;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from registers, no input-to-output path.
  // ---------------------------------------------------------------------------
  assign bus.dout         = dout_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.data_count   = count_q;
  assign bus.wr_ack       = (state_q == ST_WRITE) || (state_q == ST_WR_RD);
  assign bus.rd_ack       = (state_q == ST_READ)  || (state_q == ST_WR_RD);
  assign bus.wr_err       = (state_q == ST_WR_ERROR);
  assign bus.rd_err       = (state_q == ST_RD_ERROR) || rd_rej_q;

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO with a registered control state machine, pointer/count arithmetic and flag generation. It supersedes the fixed 8-entry combinational address calculator. It adds data storage, configurable width and depth, simultaneous read/write, almost-full/almost-empty thresholds and per-request acknowledge/error pulses. It sits between the operand producer and the factorial datapath, and is reused wherever the design needs a small command or data queue.

## Interface
- DATA_WIDTH, 32, width of each entry
- ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH (legal 1..8)
- AFULL_TH, DEPTH-1, almost_full asserted when data_count >= AFULL_TH
- AEMPTY_TH, 1, almost_empty asserted when data_count <= AEMPTY_TH
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  write request, sampled at rising edge
- rd_en  in  1  read request, sampled at rising edge
- din  in  DATA_WIDTH  write data, captured with accepted write
- dout  out  DATA_WIDTH  read data, registered
- full / empty  out  1  registered status flags
- almost_full / almost_empty  out  1  registered threshold flags
- data_count  out  ADDR_WIDTH+1  registered occupancy, 0..DEPTH
- wr_ack / rd_ack  out  1  one-cycle pulse: previous-cycle request accepted
- wr_err / rd_err  out  1  one-cycle pulse: previous-cycle request rejected (overflow/underflow)

## Operation
- Next state is computed from (wr_en, rd_en, full, empty) at every edge.
  - IDLE 000: no request.
  - WRITE 001: wr_en only and not full.
  - READ 010: rd_en only and not empty.
  - WR_ERROR 011: wr_en only and full.
  - RD_ERROR 100: rd_en only and empty.
  - WR_RD 101: both requested and not empty.
- Both requested while empty: state WRITE. The write is accepted; the read is rejected and rd_err pulses.
- Both requested while full: state WR_RD. Both are accepted and the count is unchanged. The read returns the old head entry (read-before-write at the same address).
- WRITE: mem[tail] <= din; tail+1; count+1.
- READ: dout <= mem[head]; head+1; count-1.
- WR_RD: both actions are performed; count is unchanged.
- Error states: pointers, count and memory are unchanged.
- Pointer arithmetic:
  - head and tail are ADDR_WIDTH bits and wrap modulo DEPTH naturally.
  - count is ADDR_WIDTH+1 bits and never leaves 0..DEPTH.
- Flag derivation from the next count:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - almost_full = (count >= AFULL_TH)
  - almost_empty = (count <= AEMPTY_TH)
- Pulse derivation from the registered state and request flags:
  - wr_ack = (state==WRITE or WR_RD)
  - rd_ack = (state==READ or WR_RD)
  - wr_err = (state==WR_ERROR)
  - rd_err = (state==RD_ERROR), or the read was rejected in the empty-with-both case.
- dout holds its last value when no read is accepted.

## Timing
- Reset (asynchronous, immediate):
  - head = tail = count = 0; state IDLE; dout = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - All ack/err pulses = 0.
  - Memory contents are don't-care.
- Reset asserted mid-operation discards all entries. The first edge after deassertion treats the FIFO as empty.
- Write latency: data accepted at edge N is readable by a read request sampled at edge N+1.
- Read latency: for a read accepted at edge N, dout is valid after edge N, together with rd_ack. One cycle from request to data.
- Flags and data_count update at the same edge as the accepted operation. No combinational path from inputs to outputs.
- Back-to-back requests every cycle are supported at full throughput.

## Structure
- Package fifo_pkg holds:
  - the 3-bit state encodings above;
  - a function computing DEPTH from ADDR_WIDTH.
- Sub-module fifo_p_cal_addr: purely combinational. It maps (state, head, tail, count) to (we, re, next_head, next_tail, next_count), parametrised on ADDR_WIDTH.
- The top instantiates that sub-module and contains:
  - the state register;
  - the pointer, count and flag registers;
  - the DEPTH×DATA_WIDTH register-array memory.

## Test plan
- Reset, then 8 writes of 0x11..0x88 (DEPTH 8):
  - data_count steps 1..8;
  - almost_full at count 7; full at 8;
  - wr_ack pulses 8 times.
- Full, wr_en with din=0x99:
  - wr_err pulses and count stays 8;
  - a later drain returns 0x11..0x88 with no 0x99.
- Empty, rd_en:
  - rd_err pulses, dout unchanged, count 0, empty stays 1.
- Full, wr_en and rd_en with din=0xAA:
  - dout=0x11, count stays 8;
  - draining yields 0x22..0x88 then 0xAA, exercising head/tail wrap.
- Empty, wr_en and rd_en with din=0x55:
  - wr_ack=1 and rd_err=1, count 1;
  - the next read gives 0x55.
- Reset asserted for half a cycle with count 5:
  - all outputs return to reset values immediately;
  - a write then read of 0x77 returns 0x77.
